// File: rtl/cbx_param_cfgbuf.sv
// Parametrised X-channel connection block with a double-buffered configuration chain.
// Channel tracks pass straight through; each grid input pin is a mux over channel tracks
// whose select comes from an active register, committed atomically from a serial shadow
// chain by cfg_load.
// Optional feature macro: CBX_CFG_PARITY_EN adds one even-parity bit at the far end of
// the shadow chain (the first bit shifted in) and rejects loads whose chain parity is odd.
module cbx_param_cfgbuf #(
    parameter int unsigned CHAN_WIDTH = 9,
    parameter int unsigned NUM_IPIN   = 5,
    parameter int unsigned MUX_SIZE   = 6,
    parameter int unsigned TRACK_STEP = 4
) (
    input  logic                  prog_clk,
    input  logic                  prog_reset,
    input  logic                  ccff_en,
    input  logic                  ccff_head,
    input  logic                  cfg_load,
    input  logic [CHAN_WIDTH-1:0] chanx_left_in,
    input  logic [CHAN_WIDTH-1:0] chanx_right_in,
    output logic [CHAN_WIDTH-1:0] chanx_left_out,
    output logic [CHAN_WIDTH-1:0] chanx_right_out,
    output logic [NUM_IPIN-1:0]   ipin_out,
    output logic                  ccff_tail,
    output logic                  cfg_done,
    output logic                  cfg_err
);

    localparam int unsigned SEL_BITS  = $clog2(MUX_SIZE);
    localparam int unsigned SEL_TOTAL = NUM_IPIN * SEL_BITS;
`ifdef CBX_CFG_PARITY_EN
    localparam int unsigned PAR_BITS  = 1;
`else
    localparam int unsigned PAR_BITS  = 0;
`endif
    localparam int unsigned L         = SEL_TOTAL + PAR_BITS;
    localparam int unsigned CNT_W     = $clog2(L + 1);
    localparam int unsigned IDX_W     = (CHAN_WIDTH > 1) ? $clog2(CHAN_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(L);

    logic [L-1:0]         sh_q, sh_d;
    logic [SEL_TOTAL-1:0] sel_q, sel_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic                 load_ok;

    assign chanx_left_out  = chanx_right_in;
    assign chanx_right_out = chanx_left_in;
    assign ccff_tail       = sh_q[L-1];
    assign cfg_done        = (cnt_q == CNT_FULL);
    assign cfg_err         = err_q;

    // A commit is accepted only with a complete chain (and even parity when enabled).
    always_comb begin
`ifdef CBX_CFG_PARITY_EN
        load_ok = (cnt_q == CNT_FULL) && ((^sh_q) == 1'b0);
`else
        load_ok = (cnt_q == CNT_FULL);
`endif
    end

    // Next state: load decisions use the pre-shift chain and count; the shift still happens.
    always_comb begin
        sh_d  = sh_q;
        sel_d = sel_q;
        cnt_d = cnt_q;
        err_d = err_q;
        if (ccff_en) begin
            sh_d = {sh_q[L-2:0], ccff_head};
        end
        if (cfg_load) begin
            if (load_ok) begin
                sel_d = sh_q[SEL_TOTAL-1:0];
                err_d = 1'b0;
            end else begin
                err_d = 1'b1;
            end
            cnt_d = ccff_en ? CNT_W'(1) : '0;
        end else if (ccff_en && (cnt_q != CNT_FULL)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset; reset discards any partial configuration.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            sh_q  <= '0;
            sel_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            sh_q  <= sh_d;
            sel_q <= sel_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Pin muxes: input j of pin k taps track (k + (j/2)*TRACK_STEP) mod CHAN_WIDTH,
    // left side for even j, right side for odd j; unused select codes drive 0.
    always_comb begin
        int unsigned t;
        logic [IDX_W-1:0] idx;
        t        = 0;
        idx      = '0;
        ipin_out = '0;
        for (int unsigned k = 0; k < NUM_IPIN; k++) begin
            for (int unsigned j = 0; j < MUX_SIZE; j++) begin
                if (sel_q[k*SEL_BITS +: SEL_BITS] == SEL_BITS'(j)) begin
                    t   = (k + (j / 2) * TRACK_STEP) % CHAN_WIDTH;
                    idx = IDX_W'(t);
                    ipin_out[k] = (j % 2 == 0) ? chanx_left_in[idx] : chanx_right_in[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_cbx_param_cfgbuf.sv
// Self-checking bench for cbx_param_cfgbuf (default parameters).
// Honours CBX_CFG_PARITY_EN when defined for the build.
module tb_cbx_param_cfgbuf;

    localparam int CW = 9;
    localparam int NI = 5;
    localparam int MS = 6;
    localparam int TS = 4;
    localparam int SB = $clog2(MS);
`ifdef CBX_CFG_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int L = NI * SB + PB;

    logic          prog_clk = 1'b0;
    logic          prog_reset = 1'b1;
    logic          ccff_en = 1'b0;
    logic          ccff_head = 1'b0;
    logic          cfg_load = 1'b0;
    logic [CW-1:0] lin = '0;
    logic [CW-1:0] rin = '0;
    logic [CW-1:0] lout, rout;
    logic [NI-1:0] ipin;
    logic          tail, done, err;

    cbx_param_cfgbuf #(
        .CHAN_WIDTH (CW),
        .NUM_IPIN   (NI),
        .MUX_SIZE   (MS),
        .TRACK_STEP (TS)
    ) dut (
        .prog_clk        (prog_clk),
        .prog_reset      (prog_reset),
        .ccff_en         (ccff_en),
        .ccff_head       (ccff_head),
        .cfg_load        (cfg_load),
        .chanx_left_in   (lin),
        .chanx_right_in  (rin),
        .chanx_left_out  (lout),
        .chanx_right_out (rout),
        .ipin_out        (ipin),
        .ccff_tail       (tail),
        .cfg_done        (done),
        .cfg_err         (err)
    );

    always #5 prog_clk = ~prog_clk;

    typedef struct {
        logic [NI-1:0] ipin;
        logic          tail;
        logic          done;
        logic          err;
        logic [CW-1:0] lo;
        logic [CW-1:0] ro;
    } exp_t;

    exp_t expq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: chain[i] is shadow bit i (index 0 = most recently shifted).
    bit   chain[$];
    int   m_sel[NI];
    int   m_cnt;
    bit   m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    function automatic logic [NI-1:0] model_ipin(input logic [CW-1:0] l, input logic [CW-1:0] r);
        logic [NI-1:0] v;
        v = '0;
        for (int k = 0; k < NI; k++) begin
            int s;
            int t;
            s = m_sel[k];
            if (s < MS) begin
                t    = (k + (s / 2) * TS) % CW;
                v[k] = (s % 2 == 0) ? l[t] : r[t];
            end
        end
        return v;
    endfunction

    // Drive one clock cycle of stimulus and push the outputs expected after its edge.
    task automatic step(input bit en, input bit head, input bit load, input bit rst,
                        input logic [CW-1:0] l, input logic [CW-1:0] r);
        exp_t e;
        @(negedge prog_clk);
        ccff_en    = en;
        ccff_head  = head;
        cfg_load   = load;
        prog_reset = rst;
        lin        = l;
        rin        = r;
        if (rst) begin
            chain.delete();
            for (int i = 0; i < L; i++) chain.push_back(1'b0);
            for (int k = 0; k < NI; k++) m_sel[k] = 0;
            m_cnt = 0;
            m_err = 1'b0;
        end else begin
            if (load) begin
                bit par;
                bit ok;
                par = 1'b0;
                for (int i = 0; i < L; i++) par ^= chain[i];
                ok = (m_cnt == L) && (PB == 0 || par == 1'b0);
                if (ok) begin
                    for (int k = 0; k < NI; k++) begin
                        m_sel[k] = 0;
                        for (int b = 0; b < SB; b++) m_sel[k] += int'(chain[k*SB+b]) << b;
                    end
                    m_err = 1'b0;
                end else begin
                    m_err = 1'b1;
                end
                m_cnt = en ? 1 : 0;
            end else if (en && m_cnt < L) begin
                m_cnt++;
            end
            if (en) begin
                chain.push_front(head);
                void'(chain.pop_back());
            end
        end
        e.ipin = model_ipin(l, r);
        e.tail = chain[L-1];
        e.done = (m_cnt == L);
        e.err  = m_err;
        e.lo   = r;
        e.ro   = l;
        expq.push_back(e);
    endtask

    // Shift v so that shadow bit i ends up equal to v[i].
    task automatic program_chain(input logic [L-1:0] v, input logic [CW-1:0] l,
                                 input logic [CW-1:0] r);
        for (int i = L - 1; i >= 0; i--) step(1'b1, v[i], 1'b0, 1'b0, l, r);
    endtask

    function automatic logic [L-1:0] cfg_word(input int k, input int s);
        logic [L-1:0] v;
        v = '0;
        v[k*SB +: SB] = SB'(s);
        return v;
    endfunction

    // Monitor: every cycle is an output event; compare just after the active edge.
    always @(posedge prog_clk) begin
        exp_t e;
        #1;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("ipin_out", 32'(ipin), 32'(e.ipin));
            chk("ccff_tail", 32'(tail), 32'(e.tail));
            chk("cfg_done", 32'(done), 32'(e.done));
            chk("cfg_err", 32'(err), 32'(e.err));
            chk("chanx_left_out", 32'(lout), 32'(e.lo));
            chk("chanx_right_out", 32'(rout), 32'(e.ro));
        end
    end

    initial begin
        logic [L-1:0] v;
        logic [CW-1:0] lr, rr;

        // Reset state and pass-through with a fixed channel pattern.
        step(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
        step(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 9'h1AB, '0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 9'h1AB, 9'h054);

        // sel_0 = 5 taps chanx_right_in[8].
        v = cfg_word(0, 5);
`ifdef CBX_CFG_PARITY_EN
        v[L-1] = ^v[L-2:0];
`endif
        program_chain(v, '0, 9'h100);
        step(1'b0, 1'b0, 1'b1, 1'b0, '0, 9'h100);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, 9'h100);

        // Short chain then load: rejected; a full chain plus load clears the error.
        for (int i = 0; i < 7; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, '0, 9'h100);
        step(1'b0, 1'b0, 1'b1, 1'b0, '0, 9'h100);
        step(1'b0, 1'b0, 1'b0, 1'b0, 9'h0FF, 9'h100);
        program_chain(v, '0, 9'h100);
        step(1'b0, 1'b0, 1'b1, 1'b0, '0, 9'h100);

        // sel_2 = 7 is out of range: pin 2 stays low for any channel values.
        v = cfg_word(2, 7);
`ifdef CBX_CFG_PARITY_EN
        v[L-1] = ^v[L-2:0];
`endif
        program_chain(v, '0, '0);
        step(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b0, CW'($urandom), CW'($urandom));

        // Load and shift in the same cycle: load succeeds, count restarts at 1.
        v = cfg_word(1, 3) | cfg_word(4, 4);
`ifdef CBX_CFG_PARITY_EN
        v[L-1] = ^v[L-2:0];
`endif
        program_chain(v, 9'h0F0, 9'h00F);
        step(1'b1, 1'b1, 1'b1, 1'b0, 9'h0F0, 9'h00F);
        for (int i = 0; i < L; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 9'h0F0, 9'h00F);

`ifdef CBX_CFG_PARITY_EN
        // Odd parity rejected; same stream with parity bit flipped accepted.
        v = '0;
        v[0] = 1'b1;
        program_chain(v, 9'h1FF, '0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 9'h1FF, '0);
        v[L-1] = 1'b1;
        program_chain(v, 9'h1FF, '0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 9'h1FF, '0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 9'h1FF, 9'h1FF);
`endif

        // Randomized traffic, including occasional mid-shift resets.
        for (int i = 0; i < 800; i++) begin
            lr = CW'($urandom);
            rr = CW'($urandom);
            step(($urandom_range(0, 99) < 75), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 99) < 6), ($urandom_range(0, 199) == 0), lr, rr);
        end

        repeat (2) @(posedge prog_clk);
        #2;
        chk("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
